// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: widths, opcodes, fetch states.
package cpu_pkg;

  localparam int OP_W   = 5;
  localparam int ADDR_W = 11;
  localparam int INSN_W = OP_W + ADDR_W;

  // Opcode map (instruction word MSBs)
  localparam logic [4:0] OP_LDA  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_OUT  = 5'd3;
  localparam logic [4:0] OP_STR  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_JMP  = 5'd6;
  localparam logic [4:0] OP_SWAP = 5'd7;
  localparam logic [4:0] OP_SDL  = 5'd8;
  localparam logic [4:0] OP_SDH  = 5'd9;
  localparam logic [4:0] OP_HLT  = 5'd31;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/cpu_ifetch_pc.sv
// Program counter: jump load has priority over increment; wraps naturally.
module cpu_ifetch_pc #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  import cpu_pkg::*;

  // pc register; top-of-range increment rolls over to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= '0;
    else if (load) pc <= load_addr;
    else if (inc)  pc <= pc + ADDR_W'(1);
  end

endmodule

// File: rtl/cpu_ifetch.sv
// Instruction fetch: reads program memory, issues opcode/obj over valid/ready,
// applies controller jumps and stops on HLT.
module cpu_ifetch #(
  parameter int ADDR_W = 11,
  parameter int OP_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst_clk,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [OP_W+ADDR_W-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic [OP_W-1:0]        opcode,
  output logic [ADDR_W-1:0]      obj,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  input  logic                   jmp_en,
  input  logic [ADDR_W-1:0]      jmp_addr,
  output logic [ADDR_W-1:0]      pc,
  output logic                   halted
);

  import cpu_pkg::*;

  fetch_state_e      state, state_n;
  logic              flush, flush_n;
  logic              mem_req_n, ir_valid_n, halted_n;
  logic [ADDR_W-1:0] mem_addr_n, obj_n;
  logic [OP_W-1:0]   opcode_n;
  logic              pc_load, pc_inc;

  logic [OP_W-1:0]   rd_op;
  logic [ADDR_W-1:0] rd_obj;

  assign rd_op  = mem_rdata[OP_W+ADDR_W-1 -: OP_W];
  assign rd_obj = mem_rdata[ADDR_W-1:0];

  cpu_ifetch_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk       (clk),
    .rst       (rst_clk),
    .load      (pc_load),
    .load_addr (jmp_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      state    <= REQ;
      flush    <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      opcode   <= '0;
      obj      <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_n;
      flush    <= flush_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
      opcode   <= opcode_n;
      obj      <= obj_n;
      ir_valid <= ir_valid_n;
      halted   <= halted_n;
    end
  end

  // Next-state / next-output logic; a jump outranks every other event
  always_comb begin
    state_n    = state;
    flush_n    = flush;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    opcode_n   = opcode;
    obj_n      = obj;
    ir_valid_n = ir_valid;
    halted_n   = halted;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;

    unique case (state)
      REQ: begin
        if (!mem_req) begin
          // First cycle out of reset: open the request at the current target
          mem_req_n = 1'b1;
          if (jmp_en) begin
            pc_load    = 1'b1;
            mem_addr_n = jmp_addr;
          end else begin
            mem_addr_n = pc;
          end
        end else if (mem_ack) begin
          if (jmp_en) begin
            // Data belongs to the old path; restart straight at the target
            pc_load    = 1'b1;
            mem_addr_n = jmp_addr;
            flush_n    = 1'b0;
          end else if (flush) begin
            // Stale fetch from before a jump; pc already holds the target
            flush_n    = 1'b0;
            mem_addr_n = pc;
          end else if (rd_op == OP_W'(OP_HLT)) begin
            mem_req_n = 1'b0;
            halted_n  = 1'b1;
            state_n   = HALT;
          end else begin
            opcode_n   = rd_op;
            obj_n      = rd_obj;
            ir_valid_n = 1'b1;
            mem_req_n  = 1'b0;
            pc_inc     = 1'b1;
            state_n    = ISSUE;
          end
        end else if (jmp_en) begin
          // Bus read stays in flight at the old address; mark it for discard
          pc_load = 1'b1;
          flush_n = 1'b1;
        end
      end

      ISSUE: begin
        if (jmp_en) begin
          // Any handshake this cycle still completes; unaccepted insn is lost
          pc_load    = 1'b1;
          ir_valid_n = 1'b0;
          mem_req_n  = 1'b1;
          mem_addr_n = jmp_addr;
          state_n    = REQ;
        end else if (ir_valid && ir_ready) begin
          ir_valid_n = 1'b0;
          mem_req_n  = 1'b1;
          mem_addr_n = pc;
          state_n    = REQ;
        end
      end

      HALT: begin
        mem_req_n  = 1'b0;
        ir_valid_n = 1'b0;
      end

      default: begin
        state_n    = REQ;
        mem_req_n  = 1'b0;
        ir_valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Directed bench for cpu_ifetch with a variable-latency program memory model.
module tb_cpu_ifetch;

  logic        clk;
  logic        rst_clk;
  logic        mem_req;
  logic [10:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [4:0]  opcode;
  logic [10:0] obj;
  logic        ir_valid;
  logic        ir_ready;
  logic        jmp_en;
  logic [10:0] jmp_addr;
  logic [10:0] pc;
  logic        halted;

  logic [15:0] mem [0:2047];
  int          lat;
  int          wcnt;
  int          total;
  int          bad;

  cpu_ifetch #(.ADDR_W(11), .OP_W(5)) dut (
    .clk       (clk),
    .rst_clk   (rst_clk),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .opcode    (opcode),
    .obj       (obj),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .jmp_en    (jmp_en),
    .jmp_addr  (jmp_addr),
    .pc        (pc),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ack once the request has been open for lat cycles
  assign mem_ack   = mem_req && (wcnt >= lat);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or posedge rst_clk) begin
    if (rst_clk)                 wcnt <= 0;
    else if (!mem_req || mem_ack) wcnt <= 0;
    else                         wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 2048; i++) mem[i] = {5'd2, 11'(i)};
    mem[0]     = 16'h0805;  // LDA 5
    mem[1]     = 16'h1003;  // ADD 3
    mem[2]     = 16'h1807;  // OUT 7
    mem[3]     = 16'h2009;  // STR 9
    mem[11'h30] = 16'hF800; // HLT

    rst_clk = 1'b1; ir_ready = 1'b1; jmp_en = 1'b0; jmp_addr = '0; lat = 0;
    step(2);
    chk("rst_req",   mem_req,  0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_op",    opcode,   0);
    chk("rst_obj",   obj,      0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_pc",    pc,       0);
    chk("rst_halt",  halted,   0);

    // Zero-wait fetch of two instructions
    rst_clk = 1'b0;
    step(1);
    chk("first_req",  mem_req,  1);
    chk("first_addr", mem_addr, 0);
    chk("first_vld",  ir_valid, 0);
    step(1);
    chk("i0_valid", ir_valid, 1);
    chk("i0_op",    opcode,   1);
    chk("i0_obj",   obj,      5);
    chk("i0_pc",    pc,       1);
    chk("i0_req",   mem_req,  0);
    step(1);
    chk("i1_req",  mem_req,  1);
    chk("i1_addr", mem_addr, 1);
    step(1);
    chk("i1_op",    opcode,   2);
    chk("i1_obj",   obj,      3);
    chk("i1_pc",    pc,       2);
    chk("i1_valid", ir_valid, 1);

    // Decoder stall: issue must hold
    ir_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      chk("stall_op",  opcode,   2);
      chk("stall_obj", obj,      3);
      chk("stall_vld", ir_valid, 1);
      chk("stall_req", mem_req,  0);
      chk("stall_pc",  pc,       2);
    end
    ir_ready = 1'b1;
    step(1);
    chk("resume_req",  mem_req,  1);
    chk("resume_addr", mem_addr, 2);
    step(1);
    chk("i2_op", opcode, 3);
    chk("i2_obj", obj,   7);
    chk("i2_pc", pc,     3);
    step(1);
    chk("i3_addr", mem_addr, 3);
    step(1);
    chk("i3_op",  opcode,   4);
    chk("i3_vld", ir_valid, 1);
    chk("i3_pc",  pc,       4);

    // Jump during ISSUE drops the unaccepted instruction
    ir_ready = 1'b0; jmp_en = 1'b1; jmp_addr = 11'h100;
    step(1);
    jmp_en = 1'b0; ir_ready = 1'b1;
    chk("jis_vld",  ir_valid, 0);
    chk("jis_req",  mem_req,  1);
    chk("jis_addr", mem_addr, 11'h100);
    chk("jis_pc",   pc,       11'h100);
    step(1);
    chk("jtgt_vld", ir_valid, 1);
    chk("jtgt_op",  opcode,   2);
    chk("jtgt_obj", obj,      11'h100);
    chk("jtgt_pc",  pc,       11'h101);

    // Slow memory; jump in the second wait cycle flushes the pending read
    lat = 3;
    step(1);
    chk("slow_req",  mem_req,  1);
    chk("slow_addr", mem_addr, 11'h101);
    step(1);
    jmp_en = 1'b1; jmp_addr = 11'h20;
    step(1);
    jmp_en = 1'b0;
    chk("jrq_addr", mem_addr, 11'h101);
    chk("jrq_pc",   pc,       11'h20);
    chk("jrq_req",  mem_req,  1);
    chk("jrq_vld",  ir_valid, 0);
    step(1);
    chk("jrq_hold", mem_addr, 11'h101);
    chk("jrq_ack",  mem_ack,  1);
    step(1);
    chk("flush_vld",  ir_valid, 0);
    chk("flush_req",  mem_req,  1);
    chk("flush_addr", mem_addr, 11'h20);
    lat = 0;
    step(1);
    chk("f20_vld", ir_valid, 1);
    chk("f20_obj", obj,      11'h20);
    chk("f20_pc",  pc,       11'h21);

    // pc wrap at top of memory
    jmp_en = 1'b1; jmp_addr = 11'h7FF;
    step(1);
    jmp_en = 1'b0;
    chk("wrap_addr", mem_addr, 11'h7FF);
    step(1);
    chk("wrap_obj", obj, 11'h7FF);
    chk("wrap_pc",  pc,  0);
    step(1);
    chk("wrap_next", mem_addr, 0);
    chk("wrap_req",  mem_req,  1);
    step(1);
    chk("wrap_op", opcode, 1);
    chk("wrap_pc1", pc,    1);

    // HLT stops fetching; jumps ignored afterwards
    jmp_en = 1'b1; jmp_addr = 11'h30;
    step(1);
    jmp_en = 1'b0;
    chk("hlt_addr", mem_addr, 11'h30);
    step(1);
    chk("hlt_flag", halted,   1);
    chk("hlt_req",  mem_req,  0);
    chk("hlt_vld",  ir_valid, 0);
    chk("hlt_pc",   pc,       11'h30);
    jmp_en = 1'b1; jmp_addr = 11'h5;
    step(1);
    jmp_en = 1'b0;
    step(2);
    chk("hlt_jflag", halted,   1);
    chk("hlt_jreq",  mem_req,  0);
    chk("hlt_jpc",   pc,       11'h30);
    chk("hlt_jvld",  ir_valid, 0);

    // Reset pulse out of HALT, then reset in the middle of a slow read
    #2 rst_clk = 1'b1;
    #1;
    chk("r1_halt", halted,  0);
    chk("r1_pc",   pc,      0);
    chk("r1_req",  mem_req, 0);
    lat = 3;
    rst_clk = 1'b0;
    step(1);
    chk("r1_fetch", mem_req,  1);
    chk("r1_addr",  mem_addr, 0);
    step(1);
    #2 rst_clk = 1'b1;
    #1;
    chk("r2_req",  mem_req,  0);
    chk("r2_addr", mem_addr, 0);
    chk("r2_vld",  ir_valid, 0);
    chk("r2_pc",   pc,       0);
    rst_clk = 1'b0; lat = 0;
    step(1);
    chk("r2_fetch", mem_req,  1);
    chk("r2_faddr", mem_addr, 0);
    step(1);
    chk("r2_op",  opcode,   1);
    chk("r2_obj", obj,      5);
    chk("r2_pc",  pc,       1);
    chk("r2_vld", ir_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
